rv_plic_gateway: RTL and testbench

- Per-source interrupt gateway for the PLIC, directly upstream of the per-target priority/threshold arbitration stage.
- Synchronises raw interrupt lines and converts level or edge requests into one pending bit per source (ip_o), which feeds the target stage's ip_i.
- Tracks claim/complete per source so that a source cannot be re-pended while its handler is in service.
- In edge mode, counts undelivered edges up to a saturating limit so bursts are not lost.

---
 rtl/rv_plic_gw_pkg.sv | 15 +
 rtl/rv_plic_gw_cell.sv | 99 +++++++++
 rtl/rv_plic_gateway.sv | 34 +++
 tb/tb_rv_plic_gateway.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_plic_gw_pkg.sv
// Shared types for the PLIC interrupt gateway: per-source state encoding
// and the edge-counter saturation helper.
package rv_plic_gw_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_ACTIVE  = 2'd2
  } gw_state_e;

  function automatic int unsigned gw_cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/rv_plic_gw_cell.sv
// One gateway source: input synchroniser, rising-edge detect, saturating
// pending-edge counter and the idle/pending/active claim-complete FSM.
module rv_plic_gw_cell
  import rv_plic_gw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_CNT_W  = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic le_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o,
  output logic ia_o
);

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = EDGE_CNT_W'(gw_cnt_max(EDGE_CNT_W));
  localparam logic [EDGE_CNT_W-1:0] CNT_ONE = EDGE_CNT_W'(1);

  logic                  src_s;
  logic                  src_q;
  logic                  rise;
  logic                  consume;
  gw_state_e             state_q, state_d;
  logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ip_q, ia_q;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign src_s = src_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= src_i;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign src_s = sync_q[SYNC_STAGES-1];
  end

  assign rise = src_s & ~src_q;

  always_comb begin
    state_d = state_q;
    consume = 1'b0;
    case (state_q)
      GW_IDLE: begin
        if (le_i ? (cnt_q != '0) : src_s) begin
          state_d = GW_PENDING;
          consume = le_i;
        end
      end
      // claim has priority over a simultaneous complete while pending
      GW_PENDING: if (claim_i)    state_d = GW_ACTIVE;
      GW_ACTIVE:  if (complete_i) state_d = GW_IDLE;
      default:                    state_d = GW_IDLE;
    endcase
  end

  // A rise arriving in the same cycle as a consume nets out to no change.
  always_comb begin
    cnt_d = cnt_q;
    if (!le_i) begin
      cnt_d = '0;
    end else if (rise && !consume) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (!rise && consume) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= GW_IDLE;
      src_q   <= 1'b0;
      cnt_q   <= '0;
      ip_q    <= 1'b0;
      ia_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_s;
      cnt_q   <= cnt_d;
      ip_q    <= (state_d == GW_PENDING);
      ia_q    <= (state_d == GW_ACTIVE);
    end
  end

  assign ip_o = ip_q;
  assign ia_o = ia_q;

endmodule

// File: rtl/rv_plic_gateway.sv
// PLIC interrupt gateway: N_SOURCE independent per-source cells producing
// pending (ip_o) and in-service (ia_o) bits for the target arbitration stage.
module rv_plic_gateway #(
  parameter int unsigned N_SOURCE    = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_CNT_W  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] claim_i,
  input  logic [N_SOURCE-1:0] complete_i,
  output logic [N_SOURCE-1:0] ip_o,
  output logic [N_SOURCE-1:0] ia_o
);

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    rv_plic_gw_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_CNT_W  (EDGE_CNT_W)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .src_i      (src_i[i]),
      .le_i       (le_i[i]),
      .claim_i    (claim_i[i]),
      .complete_i (complete_i[i]),
      .ip_o       (ip_o[i]),
      .ia_o       (ia_o[i])
    );
  end

endmodule

// File: tb/tb_rv_plic_gateway.sv
// Self-checking bench for rv_plic_gateway: directed scenarios followed by a
// randomized phase, all checked cycle by cycle against a behavioural model.
module tb_rv_plic_gateway;

  localparam int unsigned NS   = 32;
  localparam int unsigned SYNC = 2;
  localparam int unsigned CW   = 2;
  localparam int          MAXC = (1 << CW) - 1;
  localparam int          HD   = SYNC + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] src = '0;
  logic [NS-1:0] le  = '0;
  logic [NS-1:0] clm = '0;
  logic [NS-1:0] cpl = '0;
  logic [NS-1:0] ip, ia;

  int tests  = 0;
  int failed = 0;

  // Model: history of sampled src values, pending/active flags, owed edges.
  logic [NS-1:0] hist [HD];
  logic [NS-1:0] m_pend, m_act;
  int            owed [NS];

  rv_plic_gateway #(
    .N_SOURCE    (NS),
    .SYNC_STAGES (SYNC),
    .EDGE_CNT_W  (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .src_i      (src),
    .le_i       (le),
    .claim_i    (clm),
    .complete_i (cpl),
    .ip_o       (ip),
    .ia_o       (ia)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < HD; k++) hist[k] = '0;
    m_pend = '0;
    m_act  = '0;
    for (int i = 0; i < NS; i++) owed[i] = 0;
  endtask

  // Inputs sampled at this edge are still on the bus when this runs.
  task automatic model_edge();
    logic [NS-1:0] s, q;
    bit took, rise;
    for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = src;
    s = hist[SYNC];
    q = hist[SYNC+1];
    for (int i = 0; i < NS; i++) begin
      rise = s[i] && !q[i];
      took = 0;
      if (m_act[i]) begin
        if (cpl[i]) m_act[i] = 1'b0;
      end else if (m_pend[i]) begin
        if (clm[i]) begin
          m_pend[i] = 1'b0;
          m_act[i]  = 1'b1;
        end
      end else if (le[i] ? (owed[i] > 0) : s[i]) begin
        m_pend[i] = 1'b1;
        took      = le[i];
      end
      if (!le[i]) owed[i] = 0;
      else begin
        owed[i] = owed[i] + int'(rise) - int'(took);
        if (owed[i] > MAXC) owed[i] = MAXC;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_edge();
    chk({tag, "/ip"}, ip, m_pend);
    chk({tag, "/ia"}, ia, m_act);
  endtask

  task automatic wait_ip(input int idx, input int lim, output bit ok);
    ok = 0;
    for (int c = 0; c < lim && !ok; c++) begin
      tick("wait");
      ok = ip[idx];
    end
  endtask

  task automatic serve(input int idx);
    clm[idx] = 1'b1;
    tick("claim");
    clm[idx] = 1'b0;
    cpl[idx] = 1'b1;
    tick("complete");
    cpl[idx] = 1'b0;
  endtask

  task automatic pulse(input int idx);
    src[idx] = 1'b1;
    tick("pulse_hi");
    src[idx] = 1'b0;
    tick("pulse_lo");
    tick("pulse_lo");
  endtask

  initial begin
    bit ok;
    int rounds;
    logic [NS-1:0] b3, b5, b7;
    b3 = 32'h0000_0008;
    b5 = 32'h0000_0020;
    b7 = 32'h0000_0080;
    model_reset();

    repeat (3) tick("reset");
    chk("reset_ip", ip, '0);
    chk("reset_ia", ia, '0);
    rst = 1'b0;

    // Level source 3, held high: latency, claim, complete with re-pend.
    src[3] = 1'b1;
    tick("lvl"); tick("lvl");
    chk("lvl_lat2", ip, '0);
    tick("lvl");
    chk("lvl_lat3", ip, b3);
    tick("lvl"); tick("lvl");
    clm[3] = 1'b1; tick("lvl_claim"); clm[3] = 1'b0;
    chk("lvl_claim_ip", ip, '0);
    chk("lvl_claim_ia", ia, b3);
    tick("lvl"); tick("lvl");
    cpl[3] = 1'b1; tick("lvl_cpl"); cpl[3] = 1'b0;
    chk("lvl_cpl_ia", ia, '0);
    tick("lvl_repend");
    chk("lvl_repend_ip", ip, b3);
    src[3] = 1'b0;
    serve(3);
    tick("lvl_idle");
    chk("lvl_idle_ip", ip, '0);

    // Level source 3, two-cycle pulse: pending survives the drop.
    src[3] = 1'b1;
    tick("lp"); tick("lp");
    src[3] = 1'b0;
    tick("lp");
    chk("lp_set", ip, b3);
    repeat (4) tick("lp_hold");
    chk("lp_hold", ip, b3);
    serve(3);
    tick("lp_done");
    chk("lp_done", ip | ia, '0);

    // Edge burst on source 5 while in service: counter saturates at 3.
    le[5] = 1'b1;
    tick("edge");
    pulse(5);
    wait_ip(5, 8, ok);
    chk("edge_first_ip", {31'b0, ok}, 32'd1);
    clm[5] = 1'b1; tick("edge_claim"); clm[5] = 1'b0;
    chk("edge_active", ia, b5);
    repeat (4) pulse(5);
    repeat (3) tick("edge_flush");
    cpl[5] = 1'b1; tick("edge_cpl"); cpl[5] = 1'b0;
    rounds = 0;
    repeat (5) begin
      wait_ip(5, 10, ok);
      if (ok) begin
        rounds++;
        serve(5);
      end
    end
    chk("edge_rounds", NS'(rounds), NS'(3));

    // Strobe qualification on level source 7.
    src[7] = 1'b1; tick("stb"); src[7] = 1'b0;
    wait_ip(7, 8, ok);
    chk("stb_pend", {31'b0, ok}, 32'd1);
    clm[7] = 1'b1; cpl[7] = 1'b1; tick("stb_both");
    clm[7] = 1'b0; cpl[7] = 1'b0;
    chk("stb_both_ia", ia, b7);
    clm[7] = 1'b1; tick("stb_claim_act"); clm[7] = 1'b0;
    chk("stb_claim_act", ia, b7);
    cpl[7] = 1'b1; tick("stb_cpl"); cpl[7] = 1'b0;
    chk("stb_cpl", ia, '0);
    cpl[7] = 1'b1; tick("stb_cpl_idle"); cpl[7] = 1'b0;
    chk("stb_cpl_idle", ip | ia, '0);

    // Mode switch on source 5 with two edges owed.
    pulse(5);
    wait_ip(5, 8, ok);
    chk("ms_pend", {31'b0, ok}, 32'd1);
    clm[5] = 1'b1; tick("ms_claim"); clm[5] = 1'b0;
    pulse(5); pulse(5);
    repeat (2) tick("ms_flush");
    le[5] = 1'b0;
    repeat (2) tick("ms_level");
    cpl[5] = 1'b1; tick("ms_cpl"); cpl[5] = 1'b0;
    repeat (4) tick("ms_after");
    chk("ms_no_repend", ip & b5, '0);

    // Asynchronous reset with pending/active sources and owed edges.
    le[5] = 1'b1;
    src[3] = 1'b1;
    pulse(5);
    wait_ip(5, 8, ok);
    clm[5] = 1'b1; tick("rs_claim"); clm[5] = 1'b0;
    pulse(5); pulse(5);
    chk("rs_pre_ip", ip & b3, b3);
    chk("rs_pre_ia", ia & b5, b5);
    rst = 1'b1;
    #1;
    chk("rs_async_ip", ip, '0);
    chk("rs_async_ia", ia, '0);
    model_reset();
    src = '0;
    tick("rs_hold"); tick("rs_hold");
    rst = 1'b0;
    repeat (6) tick("rs_after");
    chk("rs_after", ip | ia, '0);

    // Randomized traffic.
    le = $urandom();
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 99) le ^= $urandom() & $urandom() & $urandom();
      src ^= $urandom() & $urandom() & $urandom();
      clm = $urandom() & $urandom();
      cpl = $urandom() & $urandom();
      tick("rand");
    end
    clm = '0;
    cpl = '0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
